// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts accepted bits into a W-bit window and flags every
// window equal to Pattern (overlaps count). Also tracks a saturating match counter and
// a saturating run length of consecutive accepted 1s. All outputs are registered.
module serial_pattern_detector #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned RW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          En,
  input  logic          D,
  input  logic [W-1:0]  Pattern,
  input  logic          Clear,
  output logic [W-1:0]  Q_par,
  output logic          Valid,
  output logic          Match,
  output logic [CW-1:0] Match_count,
  output logic [RW-1:0] Run_len
);

  // Fill count only needs to reach W, then it parks there.
  localparam int unsigned FW = $clog2(W + 1);

  logic [W-1:0]  q_par_q, q_par_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          valid_q, valid_d;
  logic          match_q, match_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] run_q, run_d;

  logic [W-1:0]  window;
  logic          full_next;

  // Next-state: shift on accept, flag a match only once the window holds W real bits.
  always_comb begin
    q_par_d   = q_par_q;
    fill_d    = fill_q;
    valid_d   = valid_q;
    match_d   = 1'b0;
    count_d   = count_q;
    run_d     = run_q;
    window    = {q_par_q[W-2:0], D};
    full_next = (fill_q >= FW'(W - 1));

    if (En) begin
      q_par_d = window;
      if (fill_q != FW'(W)) begin
        fill_d = fill_q + FW'(1);
      end
      valid_d = full_next;
      match_d = full_next && (window == Pattern);
      if (D) begin
        if (run_q != {RW{1'b1}}) begin
          run_d = run_q + RW'(1);
        end
      end else begin
        run_d = '0;
      end
    end

    if (match_d && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
    // Clear wins over a simultaneous match.
    if (Clear) begin
      count_d = '0;
    end
  end

  // State register with synchronous reset taking priority over everything else.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_par_q <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      count_q <= '0;
      run_q   <= '0;
    end else begin
      q_par_q <= q_par_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      match_q <= match_d;
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign Q_par       = q_par_q;
  assign Valid       = valid_q;
  assign Match       = match_q;
  assign Match_count = count_q;
  assign Run_len     = run_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed, table-driven bench for serial_pattern_detector. A default-sized instance is
// checked against a vector table; a narrow-counter instance checks saturation.
module tb_serial_pattern_detector;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d;
  logic [3:0] pattern;
  logic       clear;

  logic [3:0] q_par_a;
  logic       valid_a;
  logic       match_a;
  logic [7:0] count_a;
  logic [3:0] run_a;

  logic [3:0] q_par_b;
  logic       valid_b;
  logic       match_b;
  logic [1:0] count_b;
  logic [1:0] run_b;

  int checks;
  int errors;

  serial_pattern_detector #(.W(4), .CW(8), .RW(4)) dut_a (
    .Clock       (clk),
    .Reset       (rst),
    .En          (en),
    .D           (d),
    .Pattern     (pattern),
    .Clear       (clear),
    .Q_par       (q_par_a),
    .Valid       (valid_a),
    .Match       (match_a),
    .Match_count (count_a),
    .Run_len     (run_a)
  );

  serial_pattern_detector #(.W(4), .CW(2), .RW(2)) dut_b (
    .Clock       (clk),
    .Reset       (rst),
    .En          (en),
    .D           (d),
    .Pattern     (pattern),
    .Clear       (clear),
    .Q_par       (q_par_b),
    .Valid       (valid_b),
    .Match       (match_b),
    .Match_count (count_b),
    .Run_len     (run_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       d;
    logic       clear;
    logic [3:0] pattern;
    logic [3:0] q_par;
    logic       valid;
    logic       match;
    logic [7:0] count;
    logic [3:0] run;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic dd, logic c, logic [3:0] p,
                              logic [3:0] q, logic v, logic m, logic [7:0] cnt,
                              logic [3:0] rl);
    vec_t t;
    t.rst = r; t.en = e; t.d = dd; t.clear = c; t.pattern = p;
    t.q_par = q; t.valid = v; t.match = m; t.count = cnt; t.run = rl;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic dd, input logic c,
                       input logic [3:0] p);
    rst = r; en = e; d = dd; clear = c; pattern = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; d = 1'b0; clear = 1'b0; pattern = 4'b0000;

    //             rst en d clr pattern   q_par   v  m  cnt run
    // Basic detection with overlap, pattern 1011.
    vecs.push_back(mk(1, 0, 0, 0, 4'b1011, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 4'b0001, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'b1011, 4'b0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 4'b0101, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 4'b1011, 1, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 4'b1011, 4'b0110, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 4'b1101, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 4'b1011, 1, 1, 2, 2));
    // Zero-fill is not data: all-zero pattern needs 4 real accepts.
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 1, 0));
    // En=0 holds window and run length while D toggles.
    vecs.push_back(mk(1, 0, 0, 0, 4'b0110, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0110, 4'b0001, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0110, 4'b0011, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0110, 4'b0110, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 0, i[0], 0, 4'b0110, 4'b0110, 0, 0, 0, 0));
    end
    // Mid-stream reset discards partial window; then Clear vs match.
    vecs.push_back(mk(1, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0001, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0011, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0111, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0001, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0011, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b0111, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b1111, 1, 1, 1, 4));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1111, 4'b1111, 1, 1, 0, 5));
    vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 4'b1111, 1, 1, 1, 6));
    vecs.push_back(mk(0, 0, 1, 0, 4'b1111, 4'b1111, 1, 0, 1, 6));
    // Pattern change applies at next accept only.
    vecs.push_back(mk(0, 1, 0, 0, 4'b1110, 4'b1110, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b1110, 4'b1110, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].clear, vecs[i].pattern);
      check("q_par", i, int'(q_par_a), int'(vecs[i].q_par));
      check("valid", i, int'(valid_a), int'(vecs[i].valid));
      check("match", i, int'(match_a), int'(vecs[i].match));
      check("match_count", i, int'(count_a), int'(vecs[i].count));
      check("run_len", i, int'(run_a), int'(vecs[i].run));
    end

    // Saturation on the narrow instance: 10 accepted 1s against pattern 1111.
    drive(1, 0, 0, 0, 4'b1111);
    check("sat_reset_count", 0, int'(count_b), 0);
    check("sat_reset_run", 0, int'(run_b), 0);
    for (int k = 1; k <= 10; k++) begin
      int exp_cnt;
      int exp_run;
      drive(0, 1, 1, 0, 4'b1111);
      exp_cnt = (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
      exp_run = (k > 3) ? 3 : k;
      check("sat_match", k, int'(match_b), (k >= 4) ? 1 : 0);
      check("sat_count", k, int'(count_b), exp_cnt);
      check("sat_run", k, int'(run_b), exp_run);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
